oam_dma_ctrl: RTL

CPU-bus arbiter and sequencer for NES sprite DMA.
- Snoops CPU writes to $4014, halts the 6502 through RDY and takes the shared address/data bus.
- Copies 256 bytes from page XX00–XXFF to the PPU OAM data port ($2004), then hands the bus back.
- Sits between the CPU core and the system bus decoder. All memory and PPU accesses pass through its bus mux.

---
 rtl/nes_bus_pkg.sv | 31 +++
 rtl/nes_bus_mux.sv | 38 +++
 rtl/oam_dma_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU-bus OAM DMA controller.
// OAM_DMA_DMC_ARB_EN adds the DMC sample-fetch states to the state enum.
package nes_bus_pkg;

  localparam logic [15:0] APU_DMA_REG  = 16'h4014;
  localparam logic [15:0] PPU_OAM_DATA = 16'h2004;

  // Value of the parity flop during a read (GET) or write (PUT) slot.
  localparam logic GET_SLOT = 1'b0;
  localparam logic PUT_SLOT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
`ifdef OAM_DMA_DMC_ARB_EN
    ,
    DMC_RD,
    DMC_PUT
`endif
  } dma_state_e;

  typedef enum logic [1:0] {
    BUS_CPU,
    BUS_DMA,
    BUS_DMC
  } bus_sel_e;

endpackage

// File: rtl/nes_bus_mux.sv
// System bus selector: the CPU, the OAM DMA engine or the DMC fetcher
// drives address, write data and direction.
module nes_bus_mux
  import nes_bus_pkg::*;
(
  input  bus_sel_e    sel,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_r_nw,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_data,
  input  logic        dma_r_nw,
  input  logic [15:0] dmc_addr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_r_nw
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    bus_addr     = cpu_addr;
    bus_data_out = cpu_data_out;
    bus_r_nw     = cpu_r_nw;
    case (sel)
      BUS_DMA: begin
        bus_addr     = dma_addr;
        bus_data_out = dma_data;
        bus_r_nw     = dma_r_nw;
      end
      BUS_DMC: begin
        bus_addr = dmc_addr;
        bus_r_nw = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// NES sprite DMA: snoops $4014 writes, halts the 6502 via RDY and copies a
// 256-byte page to $2004. OAM_DMA_DMC_ARB_EN adds APU DMC fetch arbitration.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = APU_DMA_REG,
  parameter logic [15:0] OAM_DATA_ADDR = PPU_OAM_DATA,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_r_nw,
  input  logic [7:0]  bus_data_in,
  output logic        rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_r_nw,
  output logic        dma_active,
`ifdef OAM_DMA_DMC_ARB_EN
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic        dmc_ack,
  output logic [7:0]  dmc_data,
`endif
  output logic [8:0]  xfer_count
);

  dma_state_e  state, state_nxt;
  logic        parity;
  logic [7:0]  page;
  logic [7:0]  byte_q;
  logic [8:0]  count;
  logic        dma_trig;
  logic        trig_accept;
  logic        rd_oam;
  logic        last_byte;
  bus_sel_e    sel;
  logic [15:0] dma_addr;
  logic        dma_r_nw;
  logic [15:0] dmc_bus_addr;
  logic        steal;

`ifdef OAM_DMA_DMC_ARB_EN
  logic dmc_only;
  logic trig_pend;

  assign steal        = dmc_req;
  assign dmc_bus_addr = dmc_addr;
  assign dmc_data     = bus_data_in;
  // During a standalone fetch the CPU's $4014 write is held, not dropped.
  assign trig_accept  = dma_trig && (state == IDLE || dmc_only);
`else
  assign steal        = 1'b0;
  assign dmc_bus_addr = 16'h0000;
  assign trig_accept  = dma_trig && (state == IDLE);
`endif

  assign dma_trig   = (cpu_addr == DMA_REG_ADDR) && !cpu_r_nw;
  assign rd_oam     = (state == READ) && !steal;
  assign last_byte  = (count + 9'd1) == 9'(XFER_LEN);
  assign xfer_count = count;

  always_ff @(posedge clk_ph1 or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      parity <= GET_SLOT;
      page   <= '0;
      byte_q <= '0;
      count  <= '0;
`ifdef OAM_DMA_DMC_ARB_EN
      dmc_only  <= 1'b0;
      trig_pend <= 1'b0;
`endif
    end else begin
      parity <= ~parity;
      if (trig_accept) begin
        page  <= cpu_data_out;
        count <= '0;
      end
      if (rd_oam)          byte_q <= bus_data_in;
      if (state == WRITE)  count  <= count + 9'd1;
`ifdef OAM_DMA_DMC_ARB_EN
      if (state == IDLE) begin
        dmc_only <= dmc_req && !dma_trig;
      end else if (state == DMC_RD) begin
        dmc_only  <= 1'b0;
        trig_pend <= 1'b0;
      end else if (dmc_only && dma_trig) begin
        trig_pend <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dma_trig) state_nxt = HALT;
`ifdef OAM_DMA_DMC_ARB_EN
        else if (dmc_req) state_nxt = HALT;
`endif
      end
      // The halt cycle is the first stalled read; the bus is ours from the next one.
      HALT: begin
        if (cpu_r_nw) begin
          state_nxt = (parity == GET_SLOT) ? ALIGN : READ;
`ifdef OAM_DMA_DMC_ARB_EN
          if (dmc_only) state_nxt = (parity == GET_SLOT) ? ALIGN : DMC_RD;
`endif
        end
      end
      ALIGN: begin
        state_nxt = READ;
`ifdef OAM_DMA_DMC_ARB_EN
        if (dmc_only) state_nxt = DMC_RD;
`endif
      end
      READ: begin
        state_nxt = WRITE;
`ifdef OAM_DMA_DMC_ARB_EN
        if (dmc_req) state_nxt = DMC_PUT;
`endif
      end
      WRITE: state_nxt = last_byte ? IDLE : READ;
`ifdef OAM_DMA_DMC_ARB_EN
      DMC_PUT: state_nxt = READ;
      DMC_RD:  state_nxt = (trig_pend || dma_trig) ? HALT : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy        = 1'b0;
    dma_active = 1'b0;
    sel        = BUS_CPU;
    dma_addr   = cpu_addr;
    dma_r_nw   = 1'b1;
`ifdef OAM_DMA_DMC_ARB_EN
    dmc_ack    = 1'b0;
`endif
    case (state)
      IDLE: rdy = 1'b1;
      ALIGN: begin
        dma_active = 1'b1;
        sel        = BUS_DMA;
      end
      READ: begin
        dma_active = 1'b1;
        sel        = steal ? BUS_DMC : BUS_DMA;
        dma_addr   = {page, count[7:0]};
`ifdef OAM_DMA_DMC_ARB_EN
        dmc_ack    = dmc_req;
`endif
      end
      WRITE: begin
        dma_active = 1'b1;
        sel        = BUS_DMA;
        dma_addr   = OAM_DATA_ADDR;
        dma_r_nw   = 1'b0;
      end
`ifdef OAM_DMA_DMC_ARB_EN
      DMC_RD: begin
        dma_active = 1'b1;
        sel        = BUS_DMC;
        dmc_ack    = 1'b1;
      end
      DMC_PUT: begin
        dma_active = 1'b1;
        sel        = BUS_DMA;
      end
`endif
      default: ;
    endcase
  end

  nes_bus_mux u_mux (
    .sel          (sel),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_r_nw     (cpu_r_nw),
    .dma_addr     (dma_addr),
    .dma_data     (byte_q),
    .dma_r_nw     (dma_r_nw),
    .dmc_addr     (dmc_bus_addr),
    .bus_addr     (bus_addr),
    .bus_data_out (bus_data_out),
    .bus_r_nw     (bus_r_nw)
  );

endmodule
